// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: request/response sequencer in front of a combinational ALU.
// Decodes ALUOp/Funct3/Funct7 when a request is accepted. It drives the ALU
// for one cycle on single-step ops. SRAI is run as a chain of 1-bit
// arithmetic shifts. The result is held until the response handshake.
// Optional feature: define ALU_SEQ_ERR_EN to add the resp_err output, which
// flags unsupported decodes.
module alu_seq_ctrl #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               ALUOp,
    input  logic [2:0]               Funct3,
    input  logic [6:0]               Funct7,
    input  logic [DATA_WIDTH-1:0]    OpA,
    input  logic [DATA_WIDTH-1:0]    OpB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [DATA_WIDTH-1:0]    ALUResult,
`ifdef ALU_SEQ_ERR_EN
    output logic                     resp_err,
`endif
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    Result
);

    localparam logic [OPCODE_LENGTH-1:0] OP_AND   = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR   = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD   = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL   = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA1  = OPCODE_LENGTH'(4'b0111);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQUAL = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLT   = OPCODE_LENGTH'(4'b1100);
    localparam logic [OPCODE_LENGTH-1:0] OP_DEF   = OPCODE_LENGTH'(4'b1111);

    typedef enum logic [1:0] {IDLE, EXEC, SHIFT, RESP} state_t;
    typedef enum logic [1:0] {KIND_SINGLE, KIND_SRAI, KIND_UNSUP} kind_t;

    state_t                  state;
    kind_t                   dec_kind;
    logic [OPCODE_LENGTH-1:0] dec_op;
    logic [DATA_WIDTH-1:0]   acc;
    logic [4:0]              count;
    logic [4:0]              shamt;

    assign shamt = OpB[4:0];

    // Instruction decode of the request currently presented
    always_comb begin
        dec_op   = OP_DEF;
        dec_kind = KIND_UNSUP;
        case (ALUOp)
            2'b00: begin dec_op = OP_ADD;   dec_kind = KIND_SINGLE; end
            2'b01: begin dec_op = OP_EQUAL; dec_kind = KIND_SINGLE; end
            2'b10: begin
                case (Funct3)
                    3'b000: if (Funct7 == 7'b0000000) begin
                        dec_op = OP_ADD; dec_kind = KIND_SINGLE;
                    end
                    3'b111: begin dec_op = OP_AND; dec_kind = KIND_SINGLE; end
                    3'b100: begin dec_op = OP_XOR; dec_kind = KIND_SINGLE; end
                    3'b010: begin dec_op = OP_SLT; dec_kind = KIND_SINGLE; end
                    default: ;
                endcase
            end
            2'b11: begin
                case (Funct3)
                    3'b000: begin dec_op = OP_ADD; dec_kind = KIND_SINGLE; end
                    3'b001: begin dec_op = OP_SLL; dec_kind = KIND_SINGLE; end
                    3'b101: if (Funct7 == 7'b0100000) begin
                        dec_op = OP_SRA1; dec_kind = KIND_SRAI;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Sequencer FSM; all outputs are registered and change with the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            Result     <= '0;
            acc        <= '0;
            count      <= '0;
            Operation  <= OP_DEF;
            SrcA       <= '0;
            SrcB       <= '0;
`ifdef ALU_SEQ_ERR_EN
            resp_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        case (dec_kind)
                            KIND_SINGLE: begin
                                state     <= EXEC;
                                Operation <= dec_op;
                                SrcA      <= OpA;
                                SrcB      <= OpB;
                            end
                            KIND_SRAI: begin
                                if (shamt != 5'd0) begin
                                    state     <= SHIFT;
                                    count     <= shamt;
                                    acc       <= OpA;
                                    Operation <= OP_SRA1;
                                    SrcA      <= OpA;
                                    SrcB      <= '0;
                                end else begin
                                    // Shift by zero needs no ALU cycle
                                    state      <= RESP;
                                    Result     <= OpA;
                                    resp_valid <= 1'b1;
                                end
                            end
                            default: begin
                                state      <= RESP;
                                Result     <= '0;
                                resp_valid <= 1'b1;
`ifdef ALU_SEQ_ERR_EN
                                resp_err   <= 1'b1;
`endif
                            end
                        endcase
                    end
                end
                EXEC: begin
                    Result     <= ALUResult;
                    Operation  <= OP_DEF;
                    SrcA       <= '0;
                    SrcB       <= '0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                SHIFT: begin
                    // SrcA mirrors acc so the ALU always sees the running value
                    acc   <= ALUResult;
                    SrcA  <= ALUResult;
                    count <= count - 5'd1;
                    if (count == 5'd1) begin
                        Result     <= ALUResult;
                        Operation  <= OP_DEF;
                        SrcA       <= '0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
`ifdef ALU_SEQ_ERR_EN
                        resp_err   <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: stimulus pushes expected responses,
// a negedge monitor pops and checks them when the DUT responds.
module tb_alu_seq_ctrl;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    ALUOp;
    logic [2:0]    Funct3;
    logic [6:0]    Funct7;
    logic [DW-1:0] OpA;
    logic [DW-1:0] OpB;
    logic [3:0]    Operation;
    logic [DW-1:0] SrcA;
    logic [DW-1:0] SrcB;
    logic [DW-1:0] ALUResult;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] Result;
`ifdef ALU_SEQ_ERR_EN
    logic          resp_err;
`endif

    alu_seq_ctrl #(.DATA_WIDTH(DW), .OPCODE_LENGTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .ALUOp      (ALUOp),
        .Funct3     (Funct3),
        .Funct7     (Funct7),
        .OpA        (OpA),
        .OpB        (OpB),
        .Operation  (Operation),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUResult  (ALUResult),
`ifdef ALU_SEQ_ERR_EN
        .resp_err   (resp_err),
`endif
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .Result     (Result)
    );

    always #5 clk = ~clk;

    // Behavioural ALU the controller drives
    always_comb begin
        case (Operation)
            4'b0010: ALUResult = SrcA + SrcB;
            4'b1000: ALUResult = {31'b0, SrcA == SrcB};
            4'b0000: ALUResult = SrcA & SrcB;
            4'b0001: ALUResult = SrcA ^ SrcB;
            4'b1100: ALUResult = {31'b0, $signed(SrcA) < $signed(SrcB)};
            4'b0100: ALUResult = SrcA << SrcB[4:0];
            4'b0111: ALUResult = {SrcA[31], SrcA[31:1]};
            default: ALUResult = '0;
        endcase
    end

    typedef struct {
        logic [DW-1:0] res;
        logic [3:0]    op;
        int            alu;
        int            lat;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   acc_q[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   alu_cnt = 0;
    bit   in_resp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: tracks acceptances and ALU cycles, checks each response
    always @(negedge clk) begin
        int a;
        if (reset) begin
            acc_q.delete();
            alu_cnt = 0;
            in_resp = 0;
        end else begin
            if (req_valid && req_ready) acc_q.push_back(cyc);
            if (Operation != 4'b1111) begin
                alu_cnt++;
                if (sb.size() > 0) chk("alu_op", 32'(Operation), 32'(sb[0].op));
            end
            if (resp_valid && !in_resp) begin
                in_resp = 1;
                if (sb.size() == 0 || acc_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got resp_valid=1 required none (t=%0t)", $time);
                end else begin
                    cur = sb.pop_front();
                    a = acc_q.pop_front();
                    chk("result", Result, cur.res);
                    chk("latency", 32'(cyc - a), 32'(cur.lat));
                    chk("alu_cycles", 32'(alu_cnt), 32'(cur.alu));
                    chk("resp_op_default", 32'(Operation), 32'hF);
                    chk("resp_srca_zero", SrcA, '0);
                    chk("resp_srcb_zero", SrcB, '0);
`ifdef ALU_SEQ_ERR_EN
                    chk("resp_err", 32'(resp_err), 32'(cur.err));
`endif
                end
                alu_cnt = 0;
            end else if (resp_valid) begin
                chk("result_hold", Result, cur.res);
                chk("req_ready_in_resp", 32'(req_ready), 32'h0);
            end else begin
                in_resp = 0;
            end
        end
    end

    task automatic issue(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] res, input logic [3:0] op, input int alu,
                         input int lat, input logic err, input int hold);
        exp_t e;
        int   n;
        e.res = res; e.op = op; e.alu = alu; e.lat = lat; e.err = err;
        resp_ready = (hold == 0);
        n = 0;
        while (!req_ready && n < 40) begin @(posedge clk); #1; n++; end
        sb.push_back(e);
        ALUOp = aop; Funct3 = f3; Funct7 = f7; OpA = a; OpB = b;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 60) begin @(posedge clk); #1; n++; end
        if (!resp_valid) begin
            n_cmp++;
            n_fail++;
            $display("FAIL resp_timeout: got no resp_valid required one within 60 cycles");
        end
        if (hold > 0) begin
            repeat (hold) begin @(posedge clk); #1; end
            resp_ready = 1'b1;
        end
        @(posedge clk); #1;
        resp_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish required finish before 300000");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
        ALUOp = '0; Funct3 = '0; Funct7 = '0; OpA = '0; OpB = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_result", Result, '0);
        chk("rst_operation", 32'(Operation), 32'hF);
        chk("rst_srca", SrcA, '0);
        chk("rst_srcb", SrcB, '0);
        reset = 1'b0;
        @(posedge clk); #1;

        //    aop    f3      f7        OpA           OpB           Result        op     alu lat err hold
        issue(2'b10, 3'b000, 7'h00, 32'd5,        32'd7,        32'd12,       4'b0010, 1, 2, 0, 0);
        issue(2'b11, 3'b101, 7'h20, 32'h80000000, 32'd3,        32'hF0000000, 4'b0111, 3, 4, 0, 1);
        issue(2'b11, 3'b101, 7'h20, 32'h1234,     32'd0,        32'h1234,     4'b1111, 0, 1, 0, 2);
        issue(2'b10, 3'b010, 7'h00, 32'd3,        32'd9,        32'd1,        4'b1100, 1, 2, 0, 5);
        issue(2'b10, 3'b110, 7'h00, 32'd5,        32'd5,        32'd0,        4'b1111, 0, 1, 1, 1);
        issue(2'b00, 3'b111, 7'h7F, 32'd100,      32'd23,       32'd123,      4'b0010, 1, 2, 0, 0);
        issue(2'b01, 3'b000, 7'h00, 32'd9,        32'd9,        32'd1,        4'b1000, 1, 2, 0, 1);
        issue(2'b01, 3'b000, 7'h00, 32'd9,        32'd8,        32'd0,        4'b1000, 1, 2, 0, 0);
        issue(2'b10, 3'b111, 7'h00, 32'hF0F0,     32'h0FF0,     32'h00F0,     4'b0000, 1, 2, 0, 1);
        issue(2'b10, 3'b100, 7'h00, 32'hFF00,     32'h0FF0,     32'hF0F0,     4'b0001, 1, 2, 0, 0);
        issue(2'b10, 3'b010, 7'h00, 32'hFFFFFFFF, 32'd1,        32'd1,        4'b1100, 1, 2, 0, 1);
        issue(2'b11, 3'b001, 7'h00, 32'd1,        32'd4,        32'd16,       4'b0100, 1, 2, 0, 0);
        issue(2'b11, 3'b000, 7'h00, 32'd10,       32'hFFFFFFFD, 32'd7,        4'b0010, 1, 2, 0, 1);
        issue(2'b10, 3'b000, 7'h20, 32'd9,        32'd4,        32'd0,        4'b1111, 0, 1, 1, 0);
        issue(2'b11, 3'b101, 7'h00, 32'h80,       32'd1,        32'd0,        4'b1111, 0, 1, 1, 1);
        issue(2'b11, 3'b101, 7'h20, 32'h7FFFFFF0, 32'd1,        32'h3FFFFFF8, 4'b0111, 1, 2, 0, 0);

        // Reset during a 10-step SRAI: the operation must vanish
        resp_ready = 1'b1;
        ALUOp = 2'b11; Funct3 = 3'b101; Funct7 = 7'h20; OpA = 32'h80000000; OpB = 32'd10;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("mid_shift_op", 32'(Operation), 32'h7);
        reset = 1'b1;
        #1;
        chk("async_rst_result", Result, '0);
        chk("async_rst_op", 32'(Operation), 32'hF);
        chk("async_rst_req_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (15) begin @(posedge clk); #1; end
        chk("post_rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("post_rst_result", Result, '0);
        chk("post_rst_req_ready", 32'(req_ready), 32'h1);
        resp_ready = 1'b0;

        issue(2'b00, 3'b000, 7'h00, 32'd1,        32'd2,        32'd3,        4'b0010, 1, 2, 0, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter OPCODE_LENGTH, default 4, width of ALU Operation code.
REQ-003 SHALL use one clock and an asynchronous, active-high reset; port clk, input, 1, rising-edge clock.
REQ-004 Port reset, input, 1, asynchronous active-high reset.
REQ-005 Port req_valid, input, 1, request present.
REQ-006 Port req_ready, output, 1, request accepted when high with req_valid.
REQ-007 Port ALUOp, input, 2, class: 00 load/store add, 01 branch compare, 10 R-type, 11 I-type.
REQ-008 Port Funct3, input, 3; Port Funct7, input, 7; instruction function fields.
REQ-009 Port OpA, input, DATA_WIDTH; Port OpB, input, DATA_WIDTH; request operands.
REQ-010 Port Operation, output, OPCODE_LENGTH; Port SrcA, SrcB, output, DATA_WIDTH; drive the combinational ALU.
REQ-011 Port ALUResult, input, DATA_WIDTH, ALU output, sampled same cycle.
REQ-012 Port resp_valid, output, 1; Port resp_ready, input, 1; Port Result, output, DATA_WIDTH.

Function
REQ-013 Decode at acceptance SHALL be: ALUOp 00 -> ADD 0010; 01 -> EQUAL 1000; 10 with Funct3 000/Funct7 0000000 -> ADD, 111 -> AND 0000, 100 -> XOR 0001, 010 -> SLT 1100; 11 with Funct3 000 -> ADD, 001 -> SLLI 0100, 101/Funct7 0100000 -> SRAI; all others unsupported.
REQ-014 FSM states SHALL be IDLE, EXEC, SHIFT, RESP; req_ready=1 only in IDLE.
REQ-015 IDLE: on req_valid SHALL latch operands and decode; single-step op -> EXEC; SRAI with shamt=OpB[4:0]>0 -> SHIFT with count=shamt, acc=OpA; SRAI shamt=0 -> RESP with Result=OpA; unsupported -> RESP with Result=0.
REQ-016 EXEC: SHALL drive decoded Operation, SrcA=latched OpA, SrcB=latched OpB for exactly one cycle, register ALUResult into Result, go RESP.
REQ-017 SHIFT: SHALL drive Operation 0111, SrcA=acc, SrcB=0 each cycle; acc<=ALUResult, count<=count-1; on count==1 load Result<=ALUResult and go RESP.
REQ-018 Latency: single-step op accepted at cycle 0 SHALL present resp_valid at cycle 2; SRAI by N (N>=1) at cycle N+1.
REQ-019 RESP: resp_valid=1, Result stable until resp_ready high at a clock edge, then IDLE; resp_ready outside RESP ignored.
REQ-020 Outside EXEC/SHIFT, Operation SHALL be 1111 (ALU default) and SrcA=SrcB=0.
REQ-021 No new request SHALL be accepted in the same cycle a response completes (no overlap).
REQ-022 SLT/EQUAL results SHALL be passed through unmodified (0 or 1, zero-extended).

Reset
REQ-023 reset SHALL immediately force IDLE, req_ready=1, resp_valid=0, Result=0, acc=0, count=0, Operation=1111, SrcA=SrcB=0.
REQ-024 reset asserted mid-SHIFT or in RESP SHALL discard the operation; no response issued after release.

Configuration
REQ-025 Macro ALU_SEQ_ERR_EN defined SHALL add output port resp_err (1 bit), high with resp_valid for unsupported decodes, 0 otherwise, reset 0.
REQ-026 Without ALU_SEQ_ERR_EN, resp_err SHALL not exist; unsupported decodes still return Result=0 with normal handshake.

Verification
REQ-027 ALUOp 10, Funct3 000, Funct7 0, OpA=5, OpB=7 -> Operation 0010 one cycle, resp_valid at cycle 2, Result=12.
REQ-028 ALUOp 11, Funct3 101, Funct7 0100000, OpA=0x80000000, OpB=3 -> Operation 0111 three cycles, resp_valid at cycle 4, Result=0xF0000000 (arithmetic per ALU signedness).
REQ-029 SRAI with OpB=0, OpA=0x1234 -> no ALU cycle, resp_valid at cycle 1, Result=0x1234.
REQ-030 ALUOp 10, Funct3 010, OpA=3, OpB=9, resp_ready held low 5 cycles -> Result=1 held stable, req_ready=0 until handshake.
REQ-031 Reset pulse during SHIFT of N=10 at cycle 4 -> resp_valid stays 0, Result=0, req_ready=1 after release.
REQ-032 ALUOp 10, Funct3 110 (with ALU_SEQ_ERR_EN) -> Result=0, resp_err=1 at resp_valid.
